// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: packet-atomic 2:1 arbiter feeding the MAC tx FIFO port.
// Drops orphan words, truncates oversize frames, keeps per-source stats.
module eth_tx_arbiter #(
  parameter int MAX_WORDS = 384,
  parameter int PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [35:0] i_s0_q,
  input  logic        i_s0_empty,
  output logic        o_s0_rdreq,
  input  logic [35:0] i_s1_q,
  input  logic        i_s1_empty,
  output logic        o_s1_rdreq,
  output logic [35:0] o_tx_data,
  output logic        o_tx_vld,
  input  logic        i_tx_rdy,
  output logic [15:0] o_pkt_cnt_0,
  output logic [15:0] o_pkt_cnt_1,
  output logic [15:0] o_drop_cnt,
  output logic [15:0] o_trunc_cnt,
  output logic        o_busy
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_WORDS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;

  state_t        state, state_nx;
  logic          grant, grant_nx;
  logic          last, last_nx;
  logic [CW-1:0] wcnt, wcnt_nx;

  logic [35:0] head;
  logic        h_empty, h_sop, h_eop;
  logic        cand0, cand1, orph0, orph1;
  logic        drain0, drain1, pop_g;
  logic        vld, force_eop, acc, restart, last_word;
  logic        inc_p0, inc_p1, inc_tr;
  logic [1:0]  drop_n;

  assign head    = grant ? i_s1_q : i_s0_q;
  assign h_empty = grant ? i_s1_empty : i_s0_empty;
  assign h_sop   = head[1];
  assign h_eop   = head[0];

  assign cand0 = ~i_s0_empty & i_s0_q[1];
  assign cand1 = ~i_s1_empty & i_s1_q[1];
  assign orph0 = ~i_s0_empty & ~i_s0_q[1];
  assign orph1 = ~i_s1_empty & ~i_s1_q[1];

  assign acc       = vld & i_tx_rdy;
  assign restart   = h_sop & (wcnt != '0);
  assign last_word = ~restart & (wcnt == LAST_IDX);

  function automatic logic [15:0] sat_add(
    input logic [15:0] a,
    input logic [1:0]  b
  );
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Reset gates the pops and valid so nothing moves while rst_n is low.
  assign o_s0_rdreq = rst_n & (drain0 | (pop_g & ~grant));
  assign o_s1_rdreq = rst_n & (drain1 | (pop_g & grant));
  assign o_tx_vld   = rst_n & vld;
  assign o_tx_data  = {head[35:1], head[0] | force_eop};

  // Next-state, arbitration choice and per-cycle strobes.
  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    last_nx   = last;
    wcnt_nx   = wcnt;
    vld       = 1'b0;
    drain0    = 1'b0;
    drain1    = 1'b0;
    pop_g     = 1'b0;
    force_eop = 1'b0;
    inc_p0    = 1'b0;
    inc_p1    = 1'b0;
    inc_tr    = 1'b0;
    drop_n    = 2'd0;
    o_busy    = 1'b0;
    unique case (state)
      IDLE: begin
        drain0 = orph0;
        drain1 = orph1;
        drop_n = {1'b0, orph0} + {1'b0, orph1};
        if (cand0 | cand1) begin
          state_nx = BUSY;
          wcnt_nx  = '0;
          if (cand0 & cand1)
            grant_nx = (PRIO_MODE != 0) ? 1'b1 : ~last;
          else
            grant_nx = cand1;
        end
      end
      BUSY: begin
        o_busy    = 1'b1;
        vld       = ~h_empty;
        pop_g     = acc;
        force_eop = last_word;
        if (acc) begin
          if (h_eop) begin
            inc_p0   = ~grant;
            inc_p1   = grant;
            last_nx  = grant;
            state_nx = IDLE;
          end else if (restart) begin
            wcnt_nx = CW'(1);
          end else if (last_word) begin
            inc_p0   = ~grant;
            inc_p1   = grant;
            inc_tr   = 1'b1;
            state_nx = FLUSH;
          end else begin
            wcnt_nx = wcnt + CW'(1);
          end
        end
      end
      FLUSH: begin
        if (!h_empty) begin
          if (h_sop) begin
            last_nx  = grant;
            state_nx = IDLE;
          end else begin
            pop_g  = 1'b1;
            drop_n = 2'd1;
            if (h_eop) begin
              last_nx  = grant;
              state_nx = IDLE;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM, grant and word-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      last  <= last_nx;
      wcnt  <= wcnt_nx;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_pkt_cnt_0 <= '0;
      o_pkt_cnt_1 <= '0;
      o_drop_cnt  <= '0;
      o_trunc_cnt <= '0;
    end else begin
      o_pkt_cnt_0 <= sat_add(o_pkt_cnt_0, {1'b0, inc_p0});
      o_pkt_cnt_1 <= sat_add(o_pkt_cnt_1, {1'b0, inc_p1});
      o_drop_cnt  <= sat_add(o_drop_cnt, drop_n);
      o_trunc_cnt <= sat_add(o_trunc_cnt, {1'b0, inc_tr});
    end
  end

endmodule
